mem2io_ctrl: RTL and testbench

//  Parametrised CPU<->SRAM/MMIO bridge with a request/ready handshake and configurable SRAM wait states.

---
 rtl/mem2io_pkg.sv | 20 ++
 rtl/mem2io_if.sv | 24 ++
 rtl/mem2io_sync.sv | 22 ++
 rtl/mem2io_ctrl.sv | 126 ++++++++++++
 tb/tb_mem2io_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem2io_pkg.sv
// Shared types and helpers for the CPU<->SRAM/MMIO bridge.
// Holds the FSM state type, the MMIO window decode and the wait-state counter width.
package mem2io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WS_CNT_W = 4;

  // True when addr falls inside [base, base+n-1]; done in int so base+n may reach 2**16.
  function automatic logic io_hit(input logic [15:0] addr, input logic [15:0] base, input int n);
    int off;
    off = int'({16'h0, addr}) - int'({16'h0, base});
    return (off >= 0) && (off < n);
  endfunction

endpackage

// File: rtl/mem2io_if.sv
// CPU-side request/ready bus of the bridge; master = CPU core, slave = bridge.
// One request is outstanding at a time; ready pulses once per completed access.
interface mem2io_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic                  req;
  logic                  wr;
  logic [ADDR_W-1:0]     ADDR;
  logic [DATA_W/8-1:0]   BE_N;
  logic [DATA_W-1:0]     Data_from_CPU;
  logic [DATA_W-1:0]     Data_to_CPU;
  logic                  ready;

  modport master (
    output req, wr, ADDR, BE_N, Data_from_CPU,
    input  Data_to_CPU, ready
  );

  modport slave (
    input  req, wr, ADDR, BE_N, Data_from_CPU,
    output Data_to_CPU, ready
  );
endinterface

// File: rtl/mem2io_sync.sv
// Two-flop synchronizer for the board input channels.
// Latency 2 edges; no backpressure (free-running sampler).
module mem2io_sync #(
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/mem2io_ctrl.sv
// CPU<->SRAM/MMIO bridge; MMIO window at IO_BASE decodes NUM_IN inputs / NUM_OUT output regs.
// Latency: SRAM ready at WAIT_STATES+2 edges after accept, MMIO at 1; req ignored outside IDLE.
// Optional MEM2IO_SYNC_EN: Switches pass a 2-flop synchronizer before being read.
module mem2io_ctrl
  import mem2io_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 20,
  parameter logic [15:0] IO_BASE     = 16'hFFFF,
  parameter int          NUM_IN      = 1,
  parameter int          NUM_OUT     = 1,
  parameter int          WAIT_STATES = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  mem2io_if.slave                   bus,
  input  logic [NUM_IN*DATA_W-1:0]  Switches,
  output logic [NUM_OUT*DATA_W-1:0] HEX,
  input  logic [DATA_W-1:0]         Data_from_SRAM,
  output logic [DATA_W-1:0]         Data_to_SRAM,
  output logic [ADDR_W-1:0]         SRAM_ADDR,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N,
  output logic                      SRAM_WE_N,
  output logic [DATA_W/8-1:0]       SRAM_BE_N
);
  localparam int NB       = DATA_W / 8;
  localparam int NUM_REGS = (NUM_IN > NUM_OUT) ? NUM_IN : NUM_OUT;

  if (DATA_W % 8 != 0) begin : g_err_dw
    $error("DATA_W must be a multiple of 8");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_err_ws
    $error("WAIT_STATES must be in 0..15");
  end
  if (int'({16'h0, IO_BASE}) + NUM_REGS > 65536) begin : g_err_io
    $error("MMIO window exceeds the 16-bit address space");
  end

  state_t                state_q, state_d;
  logic [WS_CNT_W-1:0]   ws_cnt_q;
  logic [NUM_IN*DATA_W-1:0] sw_s;
  logic                  hit;
  logic                  accept;
  logic [15:0]           idx;

`ifdef MEM2IO_SYNC_EN
  mem2io_sync #(.WIDTH(NUM_IN*DATA_W)) u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Switches),
    .q     (sw_s)
  );
`else
  assign sw_s = Switches;
`endif

  assign hit    = io_hit(bus.ADDR[15:0], IO_BASE, NUM_REGS);
  assign accept = (state_q == IDLE) && bus.req;
  assign idx    = bus.ADDR[15:0] - IO_BASE;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req) state_d = hit ? DONE : MEM;
      MEM:     if (ws_cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready = (state_q == DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ws_cnt_q        <= '0;
      SRAM_ADDR       <= '0;
      Data_to_SRAM    <= '0;
      SRAM_BE_N       <= '1;
      SRAM_CE_N       <= 1'b1;
      SRAM_OE_N       <= 1'b1;
      SRAM_WE_N       <= 1'b1;
      bus.Data_to_CPU <= '0;
      HEX             <= '0;
    end else begin
      if (accept && !hit) begin
        SRAM_ADDR    <= bus.ADDR;
        Data_to_SRAM <= bus.Data_from_CPU;
        SRAM_BE_N    <= bus.BE_N;
        SRAM_CE_N    <= 1'b0;
        SRAM_OE_N    <= bus.wr;
        SRAM_WE_N    <= ~bus.wr;
        ws_cnt_q     <= WS_CNT_W'(WAIT_STATES);
      end
      if (accept && hit) begin
        if (bus.wr) begin
          for (int i = 0; i < NUM_OUT; i++)
            for (int b = 0; b < NB; b++)
              if (idx == 16'(i) && !bus.BE_N[b])
                HEX[i*DATA_W + b*8 +: 8] <= bus.Data_from_CPU[b*8 +: 8];
        end else begin
          // Indices past NUM_IN inside the window read as zero.
          bus.Data_to_CPU <= '0;
          for (int i = 0; i < NUM_IN; i++)
            if (idx == 16'(i)) bus.Data_to_CPU <= sw_s[i*DATA_W +: DATA_W];
        end
      end
      if (state_q == MEM) begin
        if (ws_cnt_q == '0) begin
          if (!SRAM_OE_N) bus.Data_to_CPU <= Data_from_SRAM;
          SRAM_CE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_WE_N <= 1'b1;
          SRAM_BE_N <= '1;
        end else begin
          ws_cnt_q <= ws_cnt_q - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem2io_ctrl.sv
// Directed bench for mem2io_ctrl with IO_BASE=FFF8, two in/out channels, two wait states.
module tb_mem2io_ctrl;
  localparam int DW = 16;
  localparam int AW = 20;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [2*DW-1:0] Switches;
  logic [2*DW-1:0] HEX;
  logic [DW-1:0] Data_from_SRAM;
  logic [DW-1:0] Data_to_SRAM;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic [1:0]    SRAM_BE_N;
  int passed = 0;
  int total  = 0;

  mem2io_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem2io_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .IO_BASE(16'hFFF8),
    .NUM_IN(2), .NUM_OUT(2), .WAIT_STATES(2)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .bus            (bus),
    .Switches       (Switches),
    .HEX            (HEX),
    .Data_from_SRAM (Data_from_SRAM),
    .Data_to_SRAM   (Data_to_SRAM),
    .SRAM_ADDR      (SRAM_ADDR),
    .SRAM_CE_N      (SRAM_CE_N),
    .SRAM_OE_N      (SRAM_OE_N),
    .SRAM_WE_N      (SRAM_WE_N),
    .SRAM_BE_N      (SRAM_BE_N)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    bus.req           = 1'b1;
    bus.wr            = w;
    bus.ADDR          = a;
    bus.Data_from_CPU = d;
    bus.BE_N          = be;
  endtask

  // Samples from the current cycle (k=1 is the cycle after the accept edge) until ready.
  task automatic wait_ready(output int lat, output int low);
    lat = 0;
    low = 0;
    for (int k = 1; k <= 20; k++) begin
      if (!SRAM_CE_N) low++;
      if (bus.ready === 1'b1) begin
        lat = k;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick;
    tick;
    total++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== 3'b111) $display("FAIL rst_strobes: got %b want 111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}); else passed++;
    total++; if (SRAM_BE_N !== 2'b11) $display("FAIL rst_be: got %b want 11", SRAM_BE_N); else passed++;
    total++; if (HEX !== 32'h0) $display("FAIL rst_hex: got %h want 0", HEX); else passed++;
    total++; if (bus.Data_to_CPU !== 16'h0 || bus.ready !== 1'b0) $display("FAIL rst_cpu: data %h ready %b want 0/0", bus.Data_to_CPU, bus.ready); else passed++;
    total++; if (SRAM_ADDR !== 20'h0 || Data_to_SRAM !== 16'h0) $display("FAIL rst_sram: addr %h data %h want 0/0", SRAM_ADDR, Data_to_SRAM); else passed++;
    Reset = 1'b0;
    tick;
  endtask

  task automatic test_mmio_write;
    drive(1'b1, 20'h0FFF9, 16'hBEEF, 2'b00);
    tick;
    bus.req = 1'b0;
    total++; if (bus.ready !== 1'b1) $display("FAIL mmio_wr_ready: got %b want 1", bus.ready); else passed++;
    total++; if (HEX !== 32'hBEEF_0000) $display("FAIL mmio_wr_full: got %h want beef0000", HEX); else passed++;
    total++; if ({SRAM_CE_N, SRAM_WE_N} !== 2'b11) $display("FAIL mmio_wr_strobes: got %b want 11", {SRAM_CE_N, SRAM_WE_N}); else passed++;
    tick;
    total++; if (bus.ready !== 1'b0) $display("FAIL mmio_wr_pulse: got %b want 0", bus.ready); else passed++;
    drive(1'b1, 20'h0FFF9, 16'h1234, 2'b10);
    tick;
    bus.req = 1'b0;
    total++; if (HEX !== 32'hBE34_0000) $display("FAIL mmio_wr_lane0: got %h want be340000", HEX); else passed++;
    tick;
    drive(1'b1, 20'h0FFF8, 16'h5566, 2'b01);
    tick;
    bus.req = 1'b0;
    total++; if (HEX !== 32'hBE34_5500) $display("FAIL mmio_wr_lane1: got %h want be345500", HEX); else passed++;
    tick;
    drive(1'b1, 20'h0FFF8, 16'hFFFF, 2'b11);
    tick;
    bus.req = 1'b0;
    total++; if (HEX !== 32'hBE34_5500 || bus.ready !== 1'b1) $display("FAIL mmio_wr_noben: hex %h ready %b want be345500/1", HEX, bus.ready); else passed++;
    tick;
  endtask

  task automatic test_sram_read;
    int lat, low;
    Data_from_SRAM = 16'hA5A5;
    drive(1'b0, 20'h00123, 16'h0000, 2'b00);
    tick;
    bus.req = 1'b0;
    total++; if (SRAM_ADDR !== 20'h00123 || {SRAM_OE_N, SRAM_WE_N} !== 2'b01 || SRAM_BE_N !== 2'b00)
      $display("FAIL sram_rd_pins: addr %h oe/we %b be %b want 00123/01/00", SRAM_ADDR, {SRAM_OE_N, SRAM_WE_N}, SRAM_BE_N); else passed++;
    wait_ready(lat, low);
    total++; if (lat !== 4) $display("FAIL sram_rd_latency: got %0d want 4", lat); else passed++;
    total++; if (low !== 3) $display("FAIL sram_rd_strobe_cycles: got %0d want 3", low); else passed++;
    total++; if (bus.Data_to_CPU !== 16'hA5A5 || SRAM_CE_N !== 1'b1) $display("FAIL sram_rd_data: data %h ce %b want a5a5/1", bus.Data_to_CPU, SRAM_CE_N); else passed++;
    Data_from_SRAM = 16'h1111;
    tick;
    total++; if (bus.Data_to_CPU !== 16'hA5A5 || bus.ready !== 1'b0 || SRAM_ADDR !== 20'h00123)
      $display("FAIL sram_rd_hold: data %h ready %b addr %h want a5a5/0/00123", bus.Data_to_CPU, bus.ready, SRAM_ADDR); else passed++;
  endtask

  task automatic test_sram_write;
    int lat, low;
    drive(1'b1, 20'h00456, 16'hCAFE, 2'b01);
    tick;
    bus.req = 1'b0;
    total++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== 3'b010 || Data_to_SRAM !== 16'hCAFE || SRAM_BE_N !== 2'b01)
      $display("FAIL sram_wr_pins: strobes %b data %h be %b want 010/cafe/01", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, Data_to_SRAM, SRAM_BE_N); else passed++;
    wait_ready(lat, low);
    total++; if (lat !== 4 || low !== 3) $display("FAIL sram_wr_timing: lat %0d low %0d want 4/3", lat, low); else passed++;
    total++; if (bus.Data_to_CPU !== 16'hA5A5) $display("FAIL sram_wr_cpu_data: got %h want a5a5", bus.Data_to_CPU); else passed++;
    tick;
  endtask

  task automatic test_mmio_read;
    int lat, low;
    logic [DW-1:0] exp_sync;
    Switches = {16'h00F0, 16'h1111};
    tick;
    tick;
    drive(1'b0, 20'h0FFF9, 16'h0000, 2'b11);
    tick;
    bus.req = 1'b0;
    total++; if (bus.ready !== 1'b1 || bus.Data_to_CPU !== 16'h00F0) $display("FAIL mmio_rd_ch1: ready %b data %h want 1/00f0", bus.ready, bus.Data_to_CPU); else passed++;
    tick;
    drive(1'b0, 20'h0FFF8, 16'h0000, 2'b11);
    tick;
    bus.req = 1'b0;
    total++; if (bus.Data_to_CPU !== 16'h1111) $display("FAIL mmio_rd_ch0: got %h want 1111", bus.Data_to_CPU); else passed++;
    tick;
    Data_from_SRAM = 16'h0000;
    drive(1'b0, 20'h0FFFC, 16'h0000, 2'b00);
    tick;
    bus.req = 1'b0;
    total++; if (SRAM_CE_N !== 1'b0 || bus.ready !== 1'b0) $display("FAIL outside_window_to_sram: ce %b ready %b want 0/0", SRAM_CE_N, bus.ready); else passed++;
    wait_ready(lat, low);
    total++; if (lat !== 4 || bus.Data_to_CPU !== 16'h0000) $display("FAIL outside_window_rd: lat %0d data %h want 4/0000", lat, bus.Data_to_CPU); else passed++;
    tick;
    Switches[31:16] = 16'h0F0F;
    tick;
    drive(1'b0, 20'h0FFF9, 16'h0000, 2'b11);
    tick;
    bus.req = 1'b0;
`ifdef MEM2IO_SYNC_EN
    exp_sync = 16'h00F0;
`else
    exp_sync = 16'h0F0F;
`endif
    total++; if (bus.Data_to_CPU !== exp_sync) $display("FAIL mmio_rd_late_change: got %h want %h", bus.Data_to_CPU, exp_sync); else passed++;
    tick;
  endtask

  task automatic test_reset_midrun;
    int seen;
    drive(1'b1, 20'h00456, 16'h7777, 2'b00);
    tick;
    bus.req = 1'b0;
    tick;
    Reset = 1'b1;
    tick;
    total++; if ({SRAM_CE_N, SRAM_WE_N} !== 2'b11 || SRAM_BE_N !== 2'b11 || bus.ready !== 1'b0)
      $display("FAIL midrst_strobes: ce/we %b be %b ready %b want 11/11/0", {SRAM_CE_N, SRAM_WE_N}, SRAM_BE_N, bus.ready); else passed++;
    total++; if (HEX !== 32'h0 || bus.Data_to_CPU !== 16'h0) $display("FAIL midrst_regs: hex %h data %h want 0/0", HEX, bus.Data_to_CPU); else passed++;
    tick;
    Reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (bus.ready !== 1'b0 || SRAM_CE_N !== 1'b1) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midrst_no_ready: got %0d active cycles want 0", seen); else passed++;
    drive(1'b0, 20'h0FFF8, 16'h0000, 2'b00);
    tick;
    bus.req = 1'b0;
    total++; if (bus.ready !== 1'b1 || bus.Data_to_CPU !== 16'h1111) $display("FAIL midrst_next_req: ready %b data %h want 1/1111", bus.ready, bus.Data_to_CPU); else passed++;
    tick;
  endtask

  task automatic test_back_to_back;
    int t[3];
    int n;
    int extra;
    Data_from_SRAM = 16'h4242;
    drive(1'b0, 20'h00200, 16'h0000, 2'b00);
    n = 0;
    for (int k = 1; k <= 40 && n < 3; k++) begin
      tick;
      if (bus.ready === 1'b1) begin
        t[n] = k;
        n++;
      end
    end
    bus.req = 1'b0;
    total++; if (n !== 3) $display("FAIL b2b_sram_count: got %0d pulses want 3", n); else passed++;
    total++; if (n == 3 && (t[1] - t[0] !== 5 || t[2] - t[1] !== 5))
      $display("FAIL b2b_sram_spacing: got %0d,%0d want 5,5", t[1] - t[0], t[2] - t[1]); else passed++;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (SRAM_CE_N !== 1'b1 || bus.ready !== 1'b0) extra++;
    end
    total++; if (extra !== 0) $display("FAIL b2b_no_extra: got %0d active cycles want 0", extra); else passed++;
    drive(1'b0, 20'h0FFF9, 16'h0000, 2'b00);
    n = 0;
    for (int k = 1; k <= 20 && n < 3; k++) begin
      tick;
      if (bus.ready === 1'b1) begin
        t[n] = k;
        n++;
      end
    end
    bus.req = 1'b0;
    total++; if (n !== 3 || t[1] - t[0] !== 2 || t[2] - t[1] !== 2)
      $display("FAIL b2b_mmio_spacing: n %0d gaps %0d,%0d want 3/2,2", n, t[1] - t[0], t[2] - t[1]); else passed++;
    tick;
    tick;
  endtask

  initial begin
    Reset             = 1'b1;
    bus.req           = 1'b0;
    bus.wr            = 1'b0;
    bus.ADDR          = '0;
    bus.BE_N          = '1;
    bus.Data_from_CPU = '0;
    Switches          = '0;
    Data_from_SRAM    = '0;
    test_reset;
    test_mmio_write;
    test_sram_read;
    test_sram_write;
    test_mmio_read;
    test_reset_midrun;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
